// File: rtl/spc_pkg.sv
// Shared constants, write payload and window decode for the SPC mailbox arbiter.
package spc_pkg;

    localparam int unsigned NUM_IP    = 5;
    localparam int unsigned WIN_BASE  = 48;
    localparam int unsigned WIN_DEPTH = 16;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned ADDR_W    = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } mbox_wr_t;

    // Index of the window holding addr, or -1 when addr lies outside every window.
    function automatic int win_index(input logic [ADDR_W-1:0] addr,
                                     input int unsigned       base,
                                     input int unsigned       depth,
                                     input int unsigned       num);
        logic [ADDR_W-1:0] off;
        if (addr < ADDR_W'(base)) return -1;
        off = (addr - ADDR_W'(base)) / ADDR_W'(depth);
        if (off >= ADDR_W'(num)) return -1;
        return int'(off);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin pick: first eligible index after last, wrapping.
module rr_arb #(
    parameter int unsigned N = 5,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt_oh_c,
    output logic [IW-1:0] gnt_idx_c,
    output logic          valid_c
);

    always_comb begin
        gnt_oh_c  = '0;
        gnt_idx_c = '0;
        valid_c   = 1'b0;
        for (int k = 1; k <= int'(N); k++) begin
            if (!valid_c && elig[IW'((int'(last) + k) % int'(N))]) begin
                valid_c            = 1'b1;
                gnt_idx_c          = IW'((int'(last) + k) % int'(N));
                gnt_oh_c[gnt_idx_c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spc_mbox_arbiter.sv
// Shares the SPC Dcache external write port among NUM_IP mailbox writers,
// tracking per-IP window occupancy against SPC reads.
module spc_mbox_arbiter #(
    parameter int unsigned NUM_IP    = spc_pkg::NUM_IP,
    parameter int unsigned WIN_BASE  = spc_pkg::WIN_BASE,
    parameter int unsigned WIN_DEPTH = spc_pkg::WIN_DEPTH
) (
    input  logic                                 PHI1,
    input  logic                                 MASRST,
    input  logic [NUM_IP-1:0]                    REQ,
    input  logic [spc_pkg::WORD_W*NUM_IP-1:0]    WDATA,
    input  logic [NUM_IP-1:0]                    IPEN,
    input  logic                                 DRead,
    input  logic [spc_pkg::ADDR_W-1:0]           DAddr,
    output logic [NUM_IP-1:0]                    GNT,
    output logic                                 DWriteE,
    output logic [spc_pkg::ADDR_W-1:0]           DAddrE,
    output logic [spc_pkg::WORD_W-1:0]           DOutE,
    output logic [NUM_IP-1:0]                    FRESH,
    output logic [NUM_IP-1:0]                    FULL,
    output logic                                 RDERR
);
    import spc_pkg::*;

    localparam int unsigned PTR_W = $clog2(WIN_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IW    = (NUM_IP > 1) ? $clog2(NUM_IP) : 1;

    logic [PTR_W-1:0]  wp_q  [NUM_IP];
    logic [PTR_W-1:0]  wp_d  [NUM_IP];
    logic [PTR_W-1:0]  rp_q  [NUM_IP];
    logic [PTR_W-1:0]  rp_d  [NUM_IP];
    logic [CNT_W-1:0]  cnt_q [NUM_IP];
    logic [CNT_W-1:0]  cnt_d [NUM_IP];
    logic [IW-1:0]     last_q, last_d;
    logic [NUM_IP-1:0] gnt_q, gnt_d;
    logic [NUM_IP-1:0] fresh_q, fresh_d;
    logic [NUM_IP-1:0] full_q, full_d;
    logic              dwe_q, dwe_d;
    logic              rderr_q, rderr_d;
    mbox_wr_t          wr_q, wr_d;

    logic [NUM_IP-1:0] elig;
    logic [NUM_IP-1:0] win_oh;
    logic [IW-1:0]     win_idx;
    logic              win_vld;
    logic [NUM_IP-1:0] wr_hit;
    logic [NUM_IP-1:0] rd_ok;
    int                rd_idx;

    // A full window stays ineligible even when the same edge frees a slot.
    assign elig = REQ & IPEN & ~full_q;

    rr_arb #(.N(NUM_IP)) u_arb (
        .elig      (elig),
        .last      (last_q),
        .gnt_oh_c  (win_oh),
        .gnt_idx_c (win_idx),
        .valid_c   (win_vld)
    );

    always_comb begin
        gnt_d   = '0;
        dwe_d   = 1'b0;
        wr_d    = wr_q;
        last_d  = last_q;
        rderr_d = rderr_q;
        wr_hit  = '0;
        rd_ok   = '0;
        fresh_d = '0;
        full_d  = '0;
        rd_idx  = win_index(DAddr, WIN_BASE, WIN_DEPTH, NUM_IP);

        if (win_vld) begin
            gnt_d     = win_oh;
            dwe_d     = 1'b1;
            last_d    = win_idx;
            wr_d.addr = ADDR_W'(WIN_BASE) + ADDR_W'(WIN_DEPTH) * ADDR_W'(win_idx)
                        + ADDR_W'(wp_q[win_idx]);
            wr_d.data = WDATA[32'(win_idx) * WORD_W +: WORD_W];
        end

        // Per-window pointer and occupancy update; a read of an empty window only flags.
        for (int i = 0; i < int'(NUM_IP); i++) begin
            wr_hit[i] = win_vld && (win_idx == IW'(i));
            if (DRead && (rd_idx == i)) begin
                if (cnt_q[i] == '0) rderr_d  = 1'b1;
                else                rd_ok[i] = 1'b1;
            end
            wp_d[i]    = wp_q[i] + PTR_W'(wr_hit[i]);
            rp_d[i]    = rp_q[i] + PTR_W'(rd_ok[i]);
            cnt_d[i]   = cnt_q[i] + CNT_W'(wr_hit[i]) - CNT_W'(rd_ok[i]);
            fresh_d[i] = (cnt_d[i] != '0);
            full_d[i]  = (cnt_d[i] == CNT_W'(WIN_DEPTH));
        end
    end

    always_ff @(posedge PHI1 or posedge MASRST) begin
        if (MASRST) begin
            for (int i = 0; i < int'(NUM_IP); i++) begin
                wp_q[i]  <= '0;
                rp_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            last_q  <= IW'(NUM_IP - 1);
            gnt_q   <= '0;
            fresh_q <= '0;
            full_q  <= '0;
            dwe_q   <= 1'b0;
            rderr_q <= 1'b0;
            wr_q    <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_IP); i++) begin
                wp_q[i]  <= wp_d[i];
                rp_q[i]  <= rp_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            fresh_q <= fresh_d;
            full_q  <= full_d;
            dwe_q   <= dwe_d;
            rderr_q <= rderr_d;
            wr_q    <= wr_d;
        end
    end

    assign GNT     = gnt_q;
    assign DWriteE = dwe_q;
    assign DAddrE  = wr_q.addr;
    assign DOutE   = wr_q.data;
    assign FRESH   = fresh_q;
    assign FULL    = full_q;
    assign RDERR   = rderr_q;

endmodule

// File: doc/spc_mbox_arbiter.md
SPC_MBOX_ARBITER -- requirements
Module: spc_mbox_arbiter

Interface
REQ-001 Parameter NUM_IP, 5, number of IP requesters sharing the SPC mailbox write port.
REQ-002 Parameter WIN_BASE, 48, word address of IP0 mailbox window.
REQ-003 Parameter WIN_DEPTH, 16, words per IP window; window i spans WIN_BASE+16*i .. WIN_BASE+16*i+15.
REQ-004 PHI1  input  1  single clock, all state on rising edge.
REQ-005 MASRST  input  1  reset, asynchronous, active-high.
REQ-006 REQ  input  NUM_IP  per-IP write request, level.
REQ-007 WDATA  input  32*NUM_IP  per-IP write word, IP i in bits [32i+31:32i].
REQ-008 IPEN  input  NUM_IP  per-IP enable from SPC policy; 0 masks the requester.
REQ-009 DRead  input  1  SPC processor data read strobe.
REQ-010 DAddr  input  32  SPC processor data read address.
REQ-011 GNT  output  NUM_IP  one-hot registered grant, one cycle per accepted word.
REQ-012 DWriteE  output  1  registered write strobe into shared Dcache external port.
REQ-013 DAddrE  output  32  registered write address.
REQ-014 DOutE  output  32  registered write data.
REQ-015 FRESH  output  NUM_IP  count_i != 0 (unread words pending).
REQ-016 FULL  output  NUM_IP  count_i == WIN_DEPTH.
REQ-017 RDERR  output  1  sticky: SPC read of empty window.

Function
REQ-018 Per IP: wp_i 4-bit, rp_i 4-bit, count_i 5-bit (0..16).
REQ-019 Eligible_i = REQ[i] & IPEN[i] & ~FULL[i], sampled at each rising edge.
REQ-020 Round-robin: winner is first eligible index after last_gnt, wrapping NUM_IP-1 -> 0; last_gnt updates only on a grant.
REQ-021 On an edge with a winner w: GNT=onehot(w), DWriteE=1, DAddrE=WIN_BASE+16*w+wp_w, DOutE=WDATA[w], wp_w wraps 15->0, count_w+1; all visible the following cycle (latency 1).
REQ-022 No winner: GNT=0, DWriteE=0, DAddrE/DOutE hold last value.
REQ-023 Each edge with REQ[i] high and granted is one word; requester deasserts REQ in the cycle GNT[i] is high to send exactly one word; held REQ yields back-to-back writes subject to round-robin.
REQ-024 SPC read: DRead=1 and DAddr inside window i -> rp_i wraps 15->0, count_i-1.
REQ-025 Read with count_i==0: pointers/count unchanged, RDERR set until reset.
REQ-026 Same-edge write and read of same IP: both pointers advance, count_i unchanged; allowed when FULL (read frees slot same edge is NOT used; FULL still blocks eligibility).
REQ-027 IPEN[i] falling with REQ pending: no further grants to i; stored words remain readable.
REQ-028 DAddr outside all windows: no effect.

Reset
REQ-029 MASRST high: wp, rp, count=0, last_gnt=NUM_IP-1 (IP0 highest priority first), GNT=0, DWriteE=0, DAddrE=0, DOutE=0, FRESH=0, FULL=0, RDERR=0, immediately and asynchronously.
REQ-030 Reset mid-write discards the in-flight word; first grant after release requires a fresh edge sample.

Structure
REQ-031 Package spc_pkg holds NUM_IP, WIN_BASE, WIN_DEPTH, word width 32, window-index decode function.
REQ-032 One sub-module rr_arb: combinational round-robin pick from eligible vector and last_gnt, returning one-hot and index.

Verification
REQ-033 Reset, REQ=5'b00001, WDATA0=0xA5A5A5A5 one cycle -> next cycle GNT=00001, DWriteE=1, DAddrE=48, DOutE=0xA5A5A5A5, FRESH[0]=1.
REQ-034 REQ=5'b11111 held 10 edges, IPEN all 1 -> grant order 0,1,2,3,4,0,1,2,3,4; DAddrE 48,64,80,96,112,49,65,81,97,113.
REQ-035 IP2 17 back-to-back requests, no reads -> 16 grants at addresses 80..95, FULL[2]=1, 17th not granted; one read at DAddr=85 -> FULL[2]=0, next grant at address 80 (wrap).
REQ-036 DRead=1, DAddr=100 with count_3=0 -> RDERR=1, count_3 stays 0; persists until MASRST.
REQ-037 IP1 count=3, same edge grant to IP1 and read at DAddr=70 -> count_1 stays 3, wp and rp each +1.
REQ-038 REQ=00011, IPEN=00010 -> only IP1 granted; MASRST pulse mid-stream -> all outputs 0 without clock edge.
